dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
Multi-cycle data-memory access stage sitting directly downstream of the core datapath.
- Consumes the datapath's ALU result (address) and store data, plus the controller's memread/memwrite.
- Runs a request/acknowledge transaction on an external data bus.
- Returns load data to the datapath's result mux, and raises stall to freeze PC and register-file write until the access completes.
- Detects misaligned accesses, bus errors and bus timeouts; any of these halts the core.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in REQ without bus_ack/bus_err before timeout fault; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
memread  input  1  controller: current instruction is a load
memwrite  input  1  controller: current instruction is a store
addr  input  32  byte address (datapath aluout)
writedata  input  32  store data (datapath writedata)
readdata  output  32  registered load data to result mux
stall  output  1  freeze core (PC, regfile write) this cycle
bus_req  output  1  bus request, registered/state-decoded
bus_we  output  1  1 = write transaction
bus_addr  output  32  word-aligned bus address
bus_wdata  output  32  bus write data
bus_ack  input  1  slave completes transaction this cycle
bus_rdata  input  32  read data, valid with bus_ack
bus_err  input  1  slave error response
fault  output  1  sticky halt indicator
fault_cause  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - readdata, bus_addr, bus_wdata = 0.
  - bus_req, bus_we, stall, fault = 0; fault_cause = 00.
  - Timeout counter = 0.
  - bus_req drops immediately even mid-transaction; the slave must tolerate an abandoned request.
- access = memread | memwrite. Both high: treated as a write.
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - access & addr[1:0]==00: capture bus_addr=addr, bus_wdata=writedata, bus_we=memwrite; next = REQ.
  - stall = 1 combinationally in this same cycle.
  - access & addr[1:0]!=00: next = FAULT, fault_cause=01; stall=1 combinationally; no bus transaction.
  - No access: stall=0, remain IDLE.
- REQ:
  - bus_req=1; bus_addr/bus_we/bus_wdata held stable; stall=1.
  - Timeout counter increments each REQ cycle (cleared on REQ entry).
  - bus_err=1 → FAULT, cause 10. bus_err wins over a simultaneous bus_ack.
  - bus_ack=1 (no err) → DONE. On a read, readdata <= bus_rdata at this edge; on a write, readdata is unchanged.
  - Counter reaches TIMEOUT_CYCLES with no ack/err → FAULT, cause 11.
  - An ack arriving in the same cycle the count reaches TIMEOUT_CYCLES is accepted (ack wins).
- DONE:
  - stall=0, bus_req=0; the core completes the instruction this cycle.
  - No new access is accepted; next = IDLE unconditionally.
- FAULT:
  - stall=1, fault=1, bus_req=0; fault_cause held. Exit only via reset.
- bus_ack/bus_err outside REQ are ignored.
- readdata holds its value until the next completed read.
- Minimum latency, ack in the first REQ cycle:
  - c0 IDLE (stall=1)
  - c1 REQ (bus_req=1, stall=1)
  - c2 DONE (stall=0, readdata valid)
  - 2 stall cycles total.
- Back-to-back accesses: the earliest new request is the cycle after DONE (IDLE).
- Outputs other than stall are registered; stall is decoded from state plus IDLE-cycle inputs.

Test Plan:
1. Aligned load, zero wait: addr=0x0000_0010, memread=1, bus_ack in first REQ cycle with bus_rdata=0xDEAD_BEEF → bus_addr=0x10, bus_we=0, stall high 2 cycles, readdata=0xDEADBEEF in DONE, bus_req high exactly 1 cycle.
2. Store with 3 wait cycles: addr=0x24, writedata=0x1234_5678, memwrite=1 → bus_we=1, bus_wdata=0x12345678 held stable 4 REQ cycles, stall high 5 cycles, readdata unchanged.
3. Misaligned: memread=1, addr=0x0000_0006 → bus_req never asserts, fault=1, fault_cause=01, stall stays 1 until reset.
4. Bus error: read to 0x40, bus_ack=1 and bus_err=1 in the same cycle → FAULT, fault_cause=10, readdata not updated.
5. Timeout: TIMEOUT_CYCLES=4, read with no ack → exactly 4 REQ cycles, then fault_cause=11. Repeat with ack on the 4th cycle → DONE, no fault.
6. Reset mid-REQ: pull reset low during the 2nd REQ cycle → bus_req, stall, readdata go to 0 immediately. After release, a new aligned load completes normally.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Multi-cycle data-memory access stage: turns load/store requests from the core into
// req/ack bus transactions, stalls the core until they complete, and halts on faults.
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DONE  = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
    // Counter holds the number of REQ cycles already elapsed, so the last allowed cycle sees N-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cause_nxt;
    logic [7:0]  cnt;
    logic        access;
    logic        aligned;

    assign access  = memread | memwrite;
    assign aligned = (addr[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        cause_nxt = fault_cause;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (aligned) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = FAULT;
                        cause_nxt = CAUSE_MISALIGN;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_err) begin
                    state_nxt = FAULT;
                    cause_nxt = CAUSE_BUS_ERR;
                end else if (bus_ack) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FAULT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                stall = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Core must see stall released while reset is held, even if access is still asserted.
        if (!reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fault_cause <= 2'b00;
            fault       <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_wdata   <= 32'h0;
            readdata    <= 32'h0;
            cnt         <= 8'h0;
        end else begin
            state       <= state_nxt;
            fault_cause <= cause_nxt;
            fault       <= (state_nxt == FAULT);
            bus_req     <= (state_nxt == REQ);
            if (state == IDLE && access && aligned) begin
                bus_addr  <= addr;
                bus_wdata <= writedata;
                bus_we    <= memwrite;
                cnt       <= 8'h0;
            end
            if (state == REQ) begin
                cnt <= cnt + 8'd1;
                if (bus_ack && !bus_err && !bus_we) begin
                    readdata <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, reset-mid-transaction sequence,
// and randomized transactions scored against an outcome-level reference model.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [31:0] addr, writedata;
    logic [31:0] readdata;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_rd = 32'h0;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata),
        .readdata(readdata), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .fault(fault), .fault_cause(fault_cause)
    );

    // resp: 0 ack, 1 err, 2 ack+err together, 3 never respond
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          wt;
        int          resp;
        logic [31:0] rdat;
        logic [1:0]  exp_cause;
        int          exp_req;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        memread = 0; memwrite = 0; bus_ack = 0; bus_err = 0;
        reset = 0;
        #2;
        reset = 1;
        model_rd = 32'h0;
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int wt, input int resp,
                           input logic [31:0] rdat, input string tag,
                           input logic [1:0] exp_cause, input int exp_req,
                           input logic [31:0] exp_rd);
        int req_cnt = 0;
        int stall_cnt = 0;
        logic held_ok = 1'b1;
        logic fin = 1'b0;
        logic [31:0] rd_end = 32'h0;
        logic [1:0] cause = 2'b00;
        logic persist_ok = 1'b1;
        @(posedge clk); #1;
        memread = rd; memwrite = wr; addr = a; writedata = wd;
        bus_ack = 0; bus_err = 0;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_req) begin
                req_cnt++;
                if (bus_addr !== a || bus_we !== wr || bus_wdata !== wd) held_ok = 1'b0;
                if (resp != 3 && req_cnt == wt + 1) begin
                    bus_ack = (resp != 1);
                    bus_err = (resp != 0);
                    bus_rdata = rdat;
                end
            end
            if (fault || !stall) begin
                fin = 1'b1;
                rd_end = readdata;
                cause = fault_cause;
            end
            @(posedge clk); #1;
            bus_ack = 0; bus_err = 0;
            if (fin) begin memread = 0; memwrite = 0; end
        end
        check({tag, " finished"}, {31'h0, fin}, 32'h1);
        check({tag, " fault_cause"}, {30'h0, cause}, {30'h0, exp_cause});
        check({tag, " req cycles"}, req_cnt, exp_req);
        check({tag, " readdata"}, rd_end, exp_rd);
        check({tag, " stall cycles"}, stall_cnt, 1 + exp_req + ((exp_cause != 2'b00) ? 1 : 0));
        if (exp_req > 0) check({tag, " bus fields held"}, {31'h0, held_ok}, 32'h1);
        if (fin && cause != 2'b00) begin
            for (int k = 0; k < 3; k++) begin
                bus_ack = 1'b1;
                @(negedge clk);
                if (!fault || !stall || bus_req || fault_cause !== cause) persist_ok = 1'b0;
            end
            check({tag, " fault sticky"}, {31'h0, persist_ok}, 32'h1);
            reset_pulse();
        end
    endtask

    // Outcome-level reference: which response wins, how many REQ cycles, what readdata becomes.
    task automatic model(input logic wr, input logic [31:0] a, input int wt, input int resp,
                         input logic [31:0] rdat, output logic [1:0] cause, output int req,
                         output logic [31:0] rd_after);
        rd_after = model_rd;
        if (a[1:0] != 2'b00) begin
            cause = 2'b01; req = 0;
        end else if (resp == 3 || wt + 1 > TO) begin
            cause = 2'b11; req = TO;
        end else begin
            req = wt + 1;
            if (resp != 0) cause = 2'b10;
            else begin
                cause = 2'b00;
                if (!wr) rd_after = rdat;
            end
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1, 0, 32'h10, 32'h0,        0, 0, 32'hDEADBEEF, 2'b00, 1, 32'hDEADBEEF};
        vecs[1]  = '{0, 1, 32'h24, 32'h12345678, 3, 0, 32'hFFFFFFFF, 2'b00, 4, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 32'h6,  32'h0,        0, 0, 32'h0,        2'b01, 0, 32'hDEADBEEF};
        vecs[3]  = '{1, 0, 32'h80, 32'h0,        1, 0, 32'hCAFE0001, 2'b00, 2, 32'hCAFE0001};
        vecs[4]  = '{1, 0, 32'h40, 32'h0,        0, 2, 32'h11112222, 2'b10, 1, 32'hCAFE0001};
        vecs[5]  = '{1, 0, 32'h50, 32'h0,        0, 3, 32'h0,        2'b11, 4, 32'h0};
        vecs[6]  = '{1, 0, 32'h54, 32'h0,        3, 0, 32'h0BADF00D, 2'b00, 4, 32'h0BADF00D};
        vecs[7]  = '{1, 1, 32'h60, 32'hAAAA5555, 2, 0, 32'h77777777, 2'b00, 3, 32'h0BADF00D};
        vecs[8]  = '{1, 0, 32'h8,  32'h0,        1, 1, 32'h0,        2'b10, 2, 32'h0BADF00D};
        vecs[9]  = '{0, 1, 32'h3,  32'h55,       0, 0, 32'h0,        2'b01, 0, 32'h0};
        vecs[10] = '{1, 0, 32'hC,  32'h0,        0, 0, 32'h13572468, 2'b00, 1, 32'h13572468};

        reset = 0; memread = 0; memwrite = 0; addr = 0; writedata = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        #13;
        check("reset outputs",
              {readdata[15:0], bus_addr[7:0], bus_wdata[3:0], stall, bus_req, bus_we, fault},
              32'h0);
        check("reset cause", {30'h0, fault_cause}, 32'h0);
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].wt, vecs[i].resp,
                    vecs[i].rdat, $sformatf("vec%0d", i), vecs[i].exp_cause,
                    vecs[i].exp_req, vecs[i].exp_rd);
        end

        // Reset during the second REQ cycle of a load.
        @(posedge clk); #1;
        memread = 1; addr = 32'h100; writedata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midreset req before", {31'h0, bus_req}, 32'h1);
        #1 reset = 0;
        #1;
        check("midreset bus_req", {31'h0, bus_req}, 32'h0);
        check("midreset stall", {31'h0, stall}, 32'h0);
        check("midreset readdata", readdata, 32'h0);
        memread = 0;
        #1 reset = 1;
        model_rd = 32'h0;
        run_txn(1, 0, 32'h200, 32'h0, 0, 0, 32'h5A5AA5A5, "after reset", 2'b00, 1, 32'h5A5AA5A5);
        model_rd = 32'h5A5AA5A5;

        for (int i = 0; i < 40; i++) begin
            logic rd, wr;
            logic [31:0] a, wd, rdat, exp_rd;
            logic [1:0] exp_cause;
            int wt, resp, r, exp_req;
            r = $urandom_range(0, 2);
            rd = (r != 1); wr = (r != 0);
            a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            wd = $urandom(); rdat = $urandom();
            wt = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            resp = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
            model(wr, a, wt, resp, rdat, exp_cause, exp_req, exp_rd);
            run_txn(rd, wr, a, wd, wt, resp, rdat, $sformatf("rand%0d", i),
                    exp_cause, exp_req, exp_rd);
            if (exp_cause == 2'b00) model_rd = exp_rd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
